// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared RV32I constants and types used by the writeback stage.
//   REG_W / ADDR_W : register width and register-index width
//   F3_*           : load funct3 encodings
//   wb_state_e     : writeback FSM state encoding
//   ld_ctx_t       : load context captured while a load waits for its ack
//   rd_we()        : write-enable qualifier (x0 is never written)
package rv32i_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic              wr_rd;
        logic [ADDR_W-1:0] rd_addr;
        logic [2:0]        funct3;
        logic [1:0]        addr_lsb;
    } ld_ctx_t;

    function automatic logic rd_we(input logic wr_rd, input logic [ADDR_W-1:0] addr);
        return wr_rd && (addr != '0);
    endfunction

endpackage

// File: rtl/rv32i_writeback_if.sv
// rv32i_writeback_if -- memory-stage to writeback-stage bundle.
//   master : memory stage (drives result/load signals, receives stall)
//   slave  : writeback stage
interface rv32i_writeback_if;
    import rv32i_pkg::*;

    logic              ce;
    logic              flush;
    logic              wr_rd;
    logic [ADDR_W-1:0] rd_addr;
    logic [REG_W-1:0]  alu_result;
    logic              is_load;
    logic [2:0]        funct3;
    logic [1:0]        addr_lsb;
    logic [REG_W-1:0]  load_data;
    logic              load_ack;
    logic              stall;

    modport master (
        output ce, flush, wr_rd, rd_addr, alu_result, is_load,
               funct3, addr_lsb, load_data, load_ack,
        input  stall
    );

    modport slave (
        input  ce, flush, wr_rd, rd_addr, alu_result, is_load,
               funct3, addr_lsb, load_data, load_ack,
        output stall
    );
endinterface

// File: rtl/rv32i_load_align.sv
// rv32i_load_align -- combinational load data extraction and extension.
//   i_funct3   : load type (LB/LH/LW/LBU/LHU; other codes give the full word)
//   i_addr_lsb : byte offset within the word
//   i_data     : raw memory word
//   o_data     : aligned, extended register value
module rv32i_load_align
    import rv32i_pkg::*;
(
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_addr_lsb,
    input  logic [REG_W-1:0] i_data,
    output logic [REG_W-1:0] o_data
);

    logic [REG_W-1:0] w_shift;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    assign w_shift = i_data >> {i_addr_lsb, 3'b000};
    assign w_byte  = w_shift[7:0];
    // Halfwords use only lsb[1]; a misaligned lsb[0] is ignored.
    assign w_half  = i_addr_lsb[1] ? i_data[31:16] : i_data[15:0];

    always_comb begin
        o_data = i_data;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/rv32i_writeback.sv
// rv32i_writeback -- RV32I writeback stage with load-ack wait state.
// Optional feature: define RV32I_WB_BYPASS_EN to add the o_byp_* forwarding
// outputs (next-edge write value, combinational).
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_ce, i_flush   : result valid / abort in-flight writeback
//   i_wr_rd, i_rd_addr, i_alu_result : non-load result
//   i_is_load, i_funct3, i_addr_lsb, i_load_data, i_load_ack : load result
//   o_stall         : combinational hold request to upstream
//   o_wr, o_rd_addr, o_rd : registered register-file write port
module rv32i_writeback
    import rv32i_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic              i_flush,
    input  logic              i_wr_rd,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [REG_W-1:0]  i_alu_result,
    input  logic              i_is_load,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lsb,
    input  logic [REG_W-1:0]  i_load_data,
    input  logic              i_load_ack,
    output logic              o_stall,
`ifdef RV32I_WB_BYPASS_EN
    output logic              o_byp_valid,
    output logic [ADDR_W-1:0] o_byp_addr,
    output logic [REG_W-1:0]  o_byp_data,
`endif
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [REG_W-1:0]  o_rd
);

    wb_state_e         r_state;
    ld_ctx_t           r_ctx;

    logic              w_in_wait;
    logic              w_ld_now;
    logic [2:0]        w_f3;
    logic [1:0]        w_lsb;
    logic [REG_W-1:0]  w_ld_data;
    logic              w_nxt_wr;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [REG_W-1:0]  w_nxt_data;

    assign w_in_wait = (r_state == ST_WAIT_LOAD);
    assign w_ld_now  = (r_state == ST_IDLE) && i_ce && i_is_load;

    // One aligner serves both paths: latched context while waiting,
    // live inputs for a same-cycle ack.
    assign w_f3  = w_in_wait ? r_ctx.funct3   : i_funct3;
    assign w_lsb = w_in_wait ? r_ctx.addr_lsb : i_addr_lsb;

    rv32i_load_align u_align (
        .i_funct3   (w_f3),
        .i_addr_lsb (w_lsb),
        .i_data     (i_load_data),
        .o_data     (w_ld_data)
    );

    always_comb begin
        w_nxt_wr   = 1'b0;
        w_nxt_addr = i_rd_addr;
        w_nxt_data = i_alu_result;
        if (!i_flush) begin
            if (w_in_wait) begin
                if (i_load_ack) begin
                    w_nxt_wr   = rd_we(r_ctx.wr_rd, r_ctx.rd_addr);
                    w_nxt_addr = r_ctx.rd_addr;
                    w_nxt_data = w_ld_data;
                end
            end else if (i_ce) begin
                if (!i_is_load) begin
                    w_nxt_wr = rd_we(i_wr_rd, i_rd_addr);
                end else if (i_load_ack) begin
                    w_nxt_wr   = rd_we(i_wr_rd, i_rd_addr);
                    w_nxt_data = w_ld_data;
                end
            end
        end
    end

    // Reset is folded in so stall cannot leak out while the FSM is held.
    assign o_stall = i_rst_n && !i_flush && !i_load_ack && (w_in_wait || w_ld_now);

`ifdef RV32I_WB_BYPASS_EN
    assign o_byp_valid = w_nxt_wr;
    assign o_byp_addr  = w_nxt_addr;
    assign o_byp_data  = w_nxt_data;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_ctx     <= '0;
            o_wr      <= 1'b0;
            o_rd_addr <= '0;
            o_rd      <= '0;
        end else begin
            o_wr <= w_nxt_wr;
            if (w_nxt_wr) begin
                o_rd_addr <= w_nxt_addr;
                o_rd      <= w_nxt_data;
            end
            if (i_flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ld_now && !i_load_ack) begin
                            r_state <= ST_WAIT_LOAD;
                            r_ctx   <= '{wr_rd: i_wr_rd, rd_addr: i_rd_addr,
                                         funct3: i_funct3, addr_lsb: i_addr_lsb};
                        end
                    end
                    ST_WAIT_LOAD: begin
                        if (i_load_ack) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/rv32i_writeback.md
RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

Interface
REQ-001 SHALL have parameter: none; all widths are fixed by the RV32I package constants.
REQ-002 SHALL have port i_clk  in  1  sole clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_ce  in  1  memory-stage result valid this cycle.
REQ-005 SHALL have port i_flush  in  1  abort any in-flight writeback.
REQ-006 SHALL have port i_wr_rd  in  1  instruction writes rd.
REQ-007 SHALL have port i_rd_addr  in  5  destination register.
REQ-008 SHALL have port i_alu_result  in  32  non-load result.
REQ-009 SHALL have port i_is_load  in  1  instruction is a load.
REQ-010 SHALL have port i_funct3  in  3  load type.
REQ-011 SHALL have port i_addr_lsb  in  2  load byte offset.
REQ-012 SHALL have port i_load_data  in  32  raw data-memory word.
REQ-013 SHALL have port i_load_ack  in  1  i_load_data valid this cycle.
REQ-014 SHALL have port o_stall  out  1  upstream must hold its outputs.
REQ-015 SHALL have port o_wr  out  1  register-file write enable.
REQ-016 SHALL have port o_rd_addr  out  5  register-file write address.
REQ-017 SHALL have port o_rd  out  32  register-file write data.

Function
REQ-018 SHALL implement states IDLE and WAIT_LOAD.
REQ-019 SHALL, in IDLE with i_ce=1 and i_is_load=0, present o_wr=i_wr_rd&&(i_rd_addr!=0), o_rd_addr=i_rd_addr, o_rd=i_alu_result on the next cycle (latency 1).
REQ-020 SHALL, in IDLE with i_ce=1, i_is_load=1 and i_load_ack=1, write the aligned load data on the next cycle and stay in IDLE.
REQ-021 SHALL, in IDLE with i_ce=1, i_is_load=1 and i_load_ack=0, latch rd_addr/wr_rd/funct3/addr_lsb, enter WAIT_LOAD, and assert o_stall combinationally from that cycle until ack.
REQ-022 SHALL, in WAIT_LOAD with i_load_ack=1, write the aligned latched-context data on the next cycle, deassert o_stall in the ack cycle, and return to IDLE.
REQ-023 SHALL ignore i_ce while in WAIT_LOAD, because upstream is holding its outputs.
REQ-024 SHALL align loads as follows: 000 LB sign-extended byte[lsb]; 001 LH sign-extended half[lsb[1]]; 100 LBU zero-extended; 101 LHU zero-extended; 010/011/110/111 full word.
REQ-025 SHALL hold o_wr=1 for exactly one cycle per retired instruction, with o_wr=0 otherwise; o_rd/o_rd_addr SHALL hold their last values when o_wr=0.
REQ-026 SHALL never assert o_wr with o_rd_addr=0.
REQ-027 SHALL give i_flush priority over everything: next state IDLE, o_wr=0 next cycle, o_stall=0 in the same cycle, and pending load context discarded.
REQ-028 SHALL ignore a late i_load_ack that arrives in IDLE with i_is_load=0.

Reset
REQ-029 SHALL, on i_rst_n=0, asynchronously force state=IDLE, o_wr=0, o_rd_addr=0, o_rd=0 and o_stall=0, including mid-WAIT_LOAD.
REQ-030 SHALL resume normal operation on the first rising edge after reset release.

Configuration
REQ-031 SHALL, with RV32I_WB_BYPASS_EN defined, add outputs o_byp_valid(1), o_byp_addr(5) and o_byp_data(32), which combinationally carry the value that will be written on the next edge, for decode-stage forwarding; o_byp_valid is gated by i_flush.
REQ-032 SHALL, without RV32I_WB_BYPASS_EN, omit these ports; all other behaviour is identical.

Structure
REQ-033 SHALL take the funct3 load encodings, state encoding and the REG_W/ADDR_W constants from the shared rv32i_pkg.
REQ-034 SHALL place load alignment in sub-module rv32i_load_align, which is purely combinational; the FSM and output registers stay in rv32i_writeback.

Verification
REQ-035 SHALL test ALU op: i_ce=1, rd=5, alu=0x1234_5678 -> next cycle o_wr=1, o_rd_addr=5, o_rd=0x1234_5678.
REQ-036 SHALL test same-cycle LB: data=0x0000_8000, lsb=1, funct3=000, ack=1 -> o_rd=0xFFFF_FF80 next cycle.
REQ-037 SHALL test a load waiting 3 cycles (LHU, data=0xBEEF_0000, lsb=2): o_stall=1 for 3 cycles -> then o_rd=0x0000_BEEF, single o_wr pulse.
REQ-038 SHALL test rd=0 with i_wr_rd=1 -> o_wr stays 0.
REQ-039 SHALL test i_flush asserted in WAIT_LOAD followed by ack -> no write, o_stall=0, state IDLE.
REQ-040 SHALL test i_rst_n pulled low mid-WAIT_LOAD -> all outputs 0 immediately; a post-reset ALU op writes normally.
